filter: RTL and testbench

Three-band (bass/mid/treble) audio equalizer datapath for 24-bit signed PCM samples, one sample per clock. Splits the input into complementary bands using a shared 8-tap delay line. Applies a per-band 2-bit gain select to each band, then sums the bands into a single output. Intermediate band and gain values are exported for debug and monitoring.

---
 rtl/filter.sv | 94 +++++++++
 tb/tb_filter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/filter.sv
// Three-band equalizer: an 8-tap delay line feeds a registered bass/mid/treble split,
// then registered per-band gain, then a registered saturating sum. One sample per clock.
module filter #(
  parameter int WD_IN  = 24,
  parameter int WD_OUT = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WD_IN-1:0]  data_in,
  input  logic [1:0]        bass_sel_in,
  input  logic [1:0]        mid_sel_in,
  input  logic [1:0]        treble_sel_in,
  output logic [WD_OUT-1:0] bass_out,
  output logic [WD_OUT-1:0] mid_out,
  output logic [WD_OUT-1:0] treble_out,
  output logic [WD_OUT-1:0] bass_eql,
  output logic [WD_OUT-1:0] mid_eql,
  output logic [WD_OUT-1:0] treble_eql,
  output logic [WD_OUT-1:0] data_out
);

  // Interface: no valid/ready handshake; data_in is consumed on every rising edge and
  // every output register advances every edge (fixed 1/2/3-cycle stage latencies).

  // Internal width holds the 8-tap sum without overflow for either port width.
  localparam int WS = ((WD_IN > WD_OUT) ? WD_IN : WD_OUT) + 3;
  localparam logic signed [WS-1:0] SAT_MAX = {{(WS-WD_OUT+1){1'b0}}, {(WD_OUT-1){1'b1}}};
  localparam logic signed [WS-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [WD_IN-1:0] x [8];
  logic signed [WS-1:0]    sum8;
  logic signed [WS-1:0]    low;
  logic signed [WS-1:0]    avg;
  logic signed [WS-1:0]    mid_d;
  logic signed [WS-1:0]    treble_d;
  logic signed [WS-1:0]    eql_sum;

  function automatic logic [WD_OUT-1:0] sat(input logic signed [WS-1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[WD_OUT-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[WD_OUT-1:0];
    else                  sat = v[WD_OUT-1:0];
  endfunction

  function automatic logic signed [WS-1:0] sext(input logic [WD_OUT-1:0] v);
    sext = WS'($signed(v));
  endfunction

  function automatic logic [WD_OUT-1:0] gain(input logic [WD_OUT-1:0] v,
                                             input logic [1:0]        sel);
    logic signed [WS-1:0] e;
    e = sext(v);
    case (sel)
      2'b00:   gain = v;
      2'b01:   gain = sat(e <<< 1);
      2'b10:   gain = sat(e >>> 1);
      default: gain = '0;
    endcase
  endfunction

  // Bands telescope: low + (avg - low) + (x0 - avg) == x0 unless a band clamps.
  always_comb begin
    sum8 = '0;
    for (int i = 0; i < 8; i++) sum8 = sum8 + WS'(x[i]);
    low      = sum8 >>> 3;
    avg      = (WS'(x[0]) + WS'(x[1])) >>> 1;
    mid_d    = avg - low;
    treble_d = WS'(x[0]) - avg;
    eql_sum  = sext(bass_eql) + sext(mid_eql) + sext(treble_eql);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) x[i] <= '0;
      bass_out   <= '0;
      mid_out    <= '0;
      treble_out <= '0;
      bass_eql   <= '0;
      mid_eql    <= '0;
      treble_eql <= '0;
      data_out   <= '0;
    end else begin
      x[0] <= data_in;
      for (int i = 1; i < 8; i++) x[i] <= x[i-1];
      bass_out   <= sat(low);
      mid_out    <= sat(mid_d);
      treble_out <= sat(treble_d);
      bass_eql   <= gain(bass_out, bass_sel_in);
      mid_eql    <= gain(mid_out, mid_sel_in);
      treble_eql <= gain(treble_out, treble_sel_in);
      data_out   <= sat(eql_sum);
    end
  end

endmodule

// File: tb/tb_filter.sv
// Bench for the three-band equalizer: directed spectra plus randomized stream against
// an arithmetic reference model, with tagged expectation queues checked by a monitor.
module tb_filter;
  localparam int W = 24;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [1:0]   bass_sel = 2'd0;
  logic [1:0]   mid_sel = 2'd0;
  logic [1:0]   treble_sel = 2'd0;
  logic [W-1:0] bass_out, mid_out, treble_out;
  logic [W-1:0] bass_eql, mid_eql, treble_eql;
  logic [W-1:0] data_out;

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt = 0;

  typedef struct {
    int           tag;
    logic [W-1:0] v0;
    logic [W-1:0] v1;
    logic [W-1:0] v2;
  } exp_t;

  exp_t band_q[$];
  exp_t eql_q[$];
  exp_t out_q[$];

  // Reference model state: recent input samples and the band triples of the last two samples.
  int hist[8];
  int bp1[3];
  int bp2[3];

  filter #(.WD_IN(W), .WD_OUT(W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .data_in       (data_in),
    .bass_sel_in   (bass_sel),
    .mid_sel_in    (mid_sel),
    .treble_sel_in (treble_sel),
    .bass_out      (bass_out),
    .mid_out       (mid_out),
    .treble_out    (treble_out),
    .bass_eql      (bass_eql),
    .mid_eql       (mid_eql),
    .treble_eql    (treble_eql),
    .data_out      (data_out)
  );

  always #5 clk = ~clk;

  function automatic int sat24(input int v);
    if (v > 8388607)  return 8388607;
    if (v < -8388608) return -8388608;
    return v;
  endfunction

  function automatic int gain_of(input int v, input logic [1:0] sel);
    case (sel)
      2'd0:    return v;
      2'd1:    return sat24(v * 2);
      2'd2:    return v >>> 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [W-1:0] to_w(input int v);
    return W'(v);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) hist[i] = 0;
    for (int i = 0; i < 3; i++) begin
      bp1[i] = 0;
      bp2[i] = 0;
    end
    band_q.delete();
    eql_q.delete();
    out_q.delete();
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, edge_cnt);
    end
  endtask

  // Drive one sample for the coming edge and record what each stage must show afterwards.
  task automatic drive(input int s, input logic [1:0] bs, input logic [1:0] ms,
                       input logic [1:0] ts);
    int   e;
    int   eq[3];
    int   b[3];
    int   sum;
    int   a;
    exp_t it;
    @(negedge clk);
    data_in    = to_w(s);
    bass_sel   = bs;
    mid_sel    = ms;
    treble_sel = ts;
    e = edge_cnt + 1;
    eq[0] = gain_of(bp2[0], bs);
    eq[1] = gain_of(bp2[1], ms);
    eq[2] = gain_of(bp2[2], ts);
    it.tag = e; it.v0 = to_w(eq[0]); it.v1 = to_w(eq[1]); it.v2 = to_w(eq[2]);
    eql_q.push_back(it);
    it.tag = e + 1; it.v0 = to_w(sat24(eq[0] + eq[1] + eq[2])); it.v1 = '0; it.v2 = '0;
    out_q.push_back(it);
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
    sum = 0;
    for (int i = 0; i < 8; i++) sum += hist[i];
    b[0] = sum >>> 3;
    a    = (hist[0] + hist[1]) >>> 1;
    b[1] = sat24(a - b[0]);
    b[2] = sat24(hist[0] - a);
    it.tag = e + 1; it.v0 = to_w(b[0]); it.v1 = to_w(b[1]); it.v2 = to_w(b[2]);
    band_q.push_back(it);
    bp2 = bp1;
    bp1 = b;
    @(posedge clk);
    edge_cnt++;
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_bass"},   bass_out,   '0);
    check({name, "_mid"},    mid_out,    '0);
    check({name, "_treble"}, treble_out, '0);
    check({name, "_beql"},   bass_eql,   '0);
    check({name, "_meql"},   mid_eql,    '0);
    check({name, "_teql"},   treble_eql, '0);
    check({name, "_out"},    data_out,   '0);
  endtask

  // Monitor: after each edge, compare every expectation tagged for that edge.
  always @(negedge clk) begin
    exp_t it;
    while (band_q.size() > 0 && band_q[0].tag <= edge_cnt) begin
      it = band_q.pop_front();
      check("bass_out",   bass_out,   it.v0);
      check("mid_out",    mid_out,    it.v1);
      check("treble_out", treble_out, it.v2);
    end
    while (eql_q.size() > 0 && eql_q[0].tag <= edge_cnt) begin
      it = eql_q.pop_front();
      check("bass_eql",   bass_eql,   it.v0);
      check("mid_eql",    mid_eql,    it.v1);
      check("treble_eql", treble_eql, it.v2);
    end
    while (out_q.size() > 0 && out_q[0].tag <= edge_cnt) begin
      it = out_q.pop_front();
      check("data_out", data_out, it.v0);
    end
  end

  initial begin
    int s;
    int prev;
    model_clear();
    // Reset held with non-zero input.
    data_in = 24'h123456;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    reset_n = 1'b1;

    // Impulse with unity gains.
    drive(256, 2'd0, 2'd0, 2'd0);
    drive(0, 2'd0, 2'd0, 2'd0);
    check("imp_bass1",   bass_out,   24'h000020);
    check("imp_mid1",    mid_out,    24'h000060);
    check("imp_treble1", treble_out, 24'h000080);
    check("imp_out_k1",  data_out,   24'h000000);
    drive(0, 2'd0, 2'd0, 2'd0);
    check("imp_bass2",   bass_out,   24'h000020);
    check("imp_mid2",    mid_out,    24'h000060);
    check("imp_treble2", treble_out, 24'hFFFF80);
    drive(0, 2'd0, 2'd0, 2'd0);
    check("imp_out_k3",  data_out,   24'h000100);
    for (int i = 4; i <= 9; i++) begin
      drive(0, 2'd0, 2'd0, 2'd0);
      if (i == 4) check("imp_out_k4", data_out, 24'h000000);
      if (i == 8) check("imp_bass_last", bass_out, 24'h000020);
      if (i == 9) check("imp_bass_gone", bass_out, 24'h000000);
    end

    // DC.
    repeat (12) drive(4096, 2'd0, 2'd0, 2'd0);
    check("dc_bass",   bass_out,   24'h001000);
    check("dc_mid",    mid_out,    24'h000000);
    check("dc_treble", treble_out, 24'h000000);
    check("dc_out",    data_out,   24'h001000);

    // Nyquist.
    for (int i = 0; i < 16; i++) drive((i % 2 == 0) ? 4096 : -4096, 2'd0, 2'd0, 2'd0);
    check("nyq_bass",   bass_out,   24'h000000);
    check("nyq_mid",    mid_out,    24'h000000);
    check("nyq_treble", treble_out, 24'h001000);
    check("nyq_out",    data_out,   24'h001000);

    // Gain selects on DC.
    repeat (12) drive(4096, 2'd1, 2'd0, 2'd0);
    check("gain_x2",     bass_eql, 24'h002000);
    check("gain_x2_out", data_out, 24'h002000);
    repeat (4) drive(4096, 2'd2, 2'd0, 2'd0);
    check("gain_half",   bass_eql, 24'h000800);
    repeat (4) drive(4096, 2'd3, 2'd0, 2'd0);
    check("gain_mute",     bass_eql, 24'h000000);
    check("gain_mute_out", data_out, 24'h000000);

    // Saturation at both rails.
    repeat (12) drive(8388607, 2'd1, 2'd0, 2'd0);
    check("sat_pos_eql", bass_eql, 24'h7FFFFF);
    repeat (12) drive(-8388608, 2'd1, 2'd0, 2'd0);
    check("sat_neg_eql", bass_eql, 24'h800000);
    check("sat_neg_out", data_out, 24'h800000);

    // Randomized stream with an asynchronous reset in the middle.
    prev = 0;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       s = 8388607;
        1:       s = -8388608;
        2:       s = int'($urandom_range(0, 8191)) - 4096;
        default: s = int'($signed(to_w(int'($urandom))));
      endcase
      drive(s, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      prev = s;
      if (n == 200) begin
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_clear();
        repeat (2) begin
          @(posedge clk);
          edge_cnt++;
        end
        #1;
        check_all_zero("reset_mid");
        reset_n = 1'b1;
      end
    end
    check("rand_last_x0_treble_path", data_in, to_w(prev));

    repeat (4) drive(0, 2'd0, 2'd0, 2'd0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
